// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back path.
// Widths of the 32x32 register file, the hard-zero register and counter.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam int WB_CNT_W = 16;

  typedef logic [WB_CNT_W-1:0] wb_cnt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr, ptr moves on advance.
// Ports: clock, ctrl_reset_n, req[N], advance -> grant[N], winner index.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clock,
  input  logic             ctrl_reset_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] winner
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W:0]   w_c;
  logic             w_found;

  // Walk ptr, ptr+1, ... wrapping at N; first valid request wins.
  always_comb begin
    grant   = '0;
    winner  = '0;
    w_found = 1'b0;
    w_c     = '0;
    for (int k = 0; k < N; k++) begin
      w_c = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_c >= (IDX_W+1)'(N))
        w_c = w_c - (IDX_W+1)'(N);
      if (!w_found && req[w_c[IDX_W-1:0]]) begin
        w_found                  = 1'b1;
        grant[w_c[IDX_W-1:0]]    = 1'b1;
        winner                   = w_c[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n)
      r_ptr <= '0;
    else if (advance)
      r_ptr <= (winner == IDX_W'(N-1)) ? '0
             : winner + 1'b1;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// Ports: req_valid/addr/data in, req_ready out, stall in;
//        registered ctrl_writeEnable/ctrl_writeReg/data_writeReg, wb_count.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
) (
  input  logic                      clock,
  input  logic                      ctrl_reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      stall,
  output logic                      ctrl_writeEnable,
  output logic [ADDR_W-1:0]         ctrl_writeReg,
  output logic [DATA_W-1:0]         data_writeReg,
  output logic [WB_CNT_W-1:0]       wb_count
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_win;
  logic               w_xfer;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_data;

  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;
  wb_cnt_t            r_cnt;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .req          (req_valid),
    .advance      (w_xfer),
    .grant        (w_grant),
    .winner       (w_win)
  );

  // Reset is folded in so nothing is accepted while the block is held.
  assign req_ready = w_grant
                   & {NUM_REQ{~stall & ctrl_reset_n}};
  assign w_xfer    = |(req_valid & req_ready);
  assign w_addr    = req_addr[w_win*ADDR_W +: ADDR_W];
  assign w_data    = req_data[w_win*DATA_W +: DATA_W];

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_xfer) begin
      r_we   <= (w_addr != ADDR_W'(REG_ZERO));
      r_addr <= w_addr;
      r_data <= w_data;
    end else begin
      r_we   <= 1'b0;
    end
  end

  // Counts writes as they are presented to the register file.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n)
      r_cnt <= '0;
    else if (r_we)
      r_cnt <= r_cnt + 1'b1;
  end

  assign ctrl_writeEnable = r_we;
  assign ctrl_writeReg    = r_addr;
  assign data_writeReg    = r_data;
  assign wb_count         = r_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a write scoreboard.
// Expected writes are queued at grant and popped when issued.
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clock = 1'b0;
  logic            ctrl_reset_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            stall;
  logic            ctrl_writeEnable;
  logic [AW-1:0]   ctrl_writeReg;
  logic [DW-1:0]   data_writeReg;
  logic [15:0]     wb_count;

  always #5 clock = ~clock;

  regfile_wb_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .req_valid        (req_valid),
    .req_addr         (req_addr),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .stall            (stall),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .wb_count         (wb_count)
  );

  int total = 0;
  int fails = 0;

  logic [AW+DW-1:0] sbq[$];
  int          grant_log[$];
  int          m_ptr;
  bit          m_we;
  logic [15:0] m_cnt;
  int          last_w;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_win();
    int c;
    if (stall) return -1;
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_req(int i, logic [AW-1:0] a,
                         logic [DW-1:0] d);
    req_valid[i]       = 1'b1;
    req_addr[i*AW+:AW] = a;
    req_data[i*DW+:DW] = d;
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_we  = 0;
    m_cnt = '0;
    sbq.delete();
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic cycle(string tag);
    int w;
    logic [N-1:0] er;
    logic [AW+DW-1:0] e;
    #1;
    w  = model_win();
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(er));
    if (w >= 0) begin
      grant_log.push_back(w);
      if (req_addr[w*AW+:AW] != '0)
        sbq.push_back({req_addr[w*AW+:AW],
                       req_data[w*DW+:DW]});
    end
    last_w = w;
    @(posedge clock);
    m_cnt = m_cnt + 16'(m_we);
    m_we  = (w >= 0) && (req_addr[w*AW+:AW] != '0);
    if (w >= 0) m_ptr = (w + 1) % N;
    @(negedge clock);
    chk({tag, "_we"}, 64'(ctrl_writeEnable), 64'(m_we));
    if (ctrl_writeEnable === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        fails++;
        $error("FAIL %s_sb: got write %0h want none",
               tag, ctrl_writeReg);
      end else begin
        e = sbq.pop_front();
        chk({tag, "_sb"},
            64'({ctrl_writeReg, data_writeReg}), 64'(e));
      end
    end
    chk({tag, "_cnt"}, 64'(wb_count), 64'(m_cnt));
  endtask

  task automatic drop_granted();
    if (last_w >= 0) req_valid[last_w] = 1'b0;
  endtask

  initial begin
    int g0;
    logic [15:0] c0;
    ctrl_reset_n = 1'b0;
    stall        = 1'b0;
    req_valid    = '1;
    req_addr     = '0;
    req_data     = '0;
    model_reset();
    last_w = -1;

    // Reset state, with requests pending
    #3;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_we",    64'(ctrl_writeEnable), 64'd0);
    chk("rst_reg",   64'(ctrl_writeReg), 64'd0);
    chk("rst_data",  64'(data_writeReg), 64'd0);
    chk("rst_cnt",   64'(wb_count), 64'd0);
    req_valid = '0;
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    for (int i = 0; i < 10; i++) cycle("idle");

    // Single write from requester 1
    set_req(1, 5'd5, 32'hDEADBEEF);
    cycle("single");
    chk("single_we",   64'(ctrl_writeEnable), 64'd1);
    chk("single_reg",  64'(ctrl_writeReg), 64'd5);
    chk("single_data", 64'(data_writeReg), 64'hDEADBEEF);
    req_valid = '0;
    cycle("single_idle");
    chk("single_cnt1", 64'(wb_count), 64'd1);

    // r0 write: consumed, not issued
    set_req(2, 5'd0, 32'h1234);
    cycle("r0");
    chk("r0_we", 64'(ctrl_writeEnable), 64'd0);
    req_valid = '0;
    cycle("r0_idle");
    chk("r0_cnt", 64'(wb_count), 64'd1);

    // Fairness: all three continuously valid
    g0 = grant_log.size();
    c0 = wb_count;
    set_req(0, 5'd1, 32'hA0);
    set_req(1, 5'd2, 32'hA1);
    set_req(2, 5'd3, 32'hA2);
    for (int i = 0; i < 9; i++) cycle("fair");
    req_valid = '0;
    cycle("fair_idle");
    cycle("fair_idle");
    for (int j = 0; j < 9; j++)
      chk("fair_order", 64'(grant_log[g0+j]), 64'(j % 3));
    chk("fair_cnt", 64'(wb_count - c0), 64'd9);

    // Stall blocks both, then ptr-order drain
    g0 = grant_log.size();
    set_req(0, 5'd10, 32'hB0);
    set_req(1, 5'd11, 32'hB1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) cycle("stall");
    stall = 1'b0;
    cycle("unstall");
    drop_granted();
    cycle("unstall");
    drop_granted();
    cycle("unstall_idle");
    chk("stall_n", 64'(grant_log.size() - g0), 64'd2);
    chk("stall_1st", 64'(grant_log[g0]), 64'd0);
    chk("stall_2nd", 64'(grant_log[g0+1]), 64'd1);

    // Async reset while a write is latched
    set_req(1, 5'd7, 32'hCAFE0001);
    #1;
    chk("mid_ready", 64'(req_ready), 64'b010);
    @(posedge clock);
    #2;
    chk("mid_we_pre", 64'(ctrl_writeEnable), 64'd1);
    ctrl_reset_n = 1'b0;
    #1;
    chk("mid_we",    64'(ctrl_writeEnable), 64'd0);
    chk("mid_reg",   64'(ctrl_writeReg), 64'd0);
    chk("mid_data",  64'(data_writeReg), 64'd0);
    chk("mid_ready0", 64'(req_ready), 64'd0);
    req_valid = '0;
    model_reset();
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    set_req(0, 5'd12, 32'hC0);
    set_req(2, 5'd13, 32'hC2);
    cycle("post_rst");
    chk("post_rst_win", 64'(last_w), 64'd0);
    drop_granted();
    cycle("post_rst");
    drop_granted();
    cycle("post_rst_idle");
    cycle("post_rst_idle");

    // Counter wrap
    ctrl_reset_n = 1'b0;
    model_reset();
    #1;
    ctrl_reset_n = 1'b1;
    @(negedge clock);
    set_req(0, 5'd1, 32'h5A5A);
    for (int i = 0; i < 65535; i++) @(posedge clock);
    @(negedge clock);
    req_valid = '0;
    @(posedge clock);
    @(negedge clock);
    chk("wrap_pre", 64'(wb_count), 64'hFFFF);
    m_cnt = 16'hFFFF;
    m_we  = 0;
    m_ptr = 1;
    sbq.delete();
    set_req(0, 5'd9, 32'h600D);
    cycle("wrap_last");
    req_valid = '0;
    cycle("wrap_settle");
    chk("wrap_zero", 64'(wb_count), 64'h0000);
    chk("sb_empty", 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
